asmd_updown_counter_p: RTL and testbench



---
 rtl/asmd_updown_counter_p_pkg.sv | 16 +
 rtl/asmd_updown_counter_p_ctrl.sv | 43 ++++
 rtl/asmd_updown_counter_p.sv | 123 ++++++++++++
 tb/tb_asmd_updown_counter_p.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/asmd_updown_counter_p_pkg.sv
// Shared state encodings and command codes for the ASMD up/down counter.
package asmd_cnt_defs;

    localparam int unsigned DIR_W = 2;

    typedef enum logic [DIR_W-1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10
    } state_e;

    localparam logic [DIR_W-1:0] CMD_HOLD = 2'b00;
    localparam logic [DIR_W-1:0] CMD_UP   = 2'b01;
    localparam logic [DIR_W-1:0] CMD_DOWN = 2'b10;

endpackage

// File: rtl/asmd_updown_counter_p_ctrl.sv
// Control FSM of the ASMD counter: latches the direction command and
// exposes incr/decr qualifiers plus the raw state encoding as dir.
module asmd_cnt_ctrl
    import asmd_cnt_defs::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIR_W-1:0] up_down,
    output logic             incr,
    output logic             decr,
    output logic [DIR_W-1:0] dir
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command is only sampled while enabled; hold/illegal codes park in idle.
    always_comb begin
        state_d = state_q;
        incr    = 1'b0;
        decr    = 1'b0;
        dir     = DIR_W'(state_q);
        if (en) begin
            case (up_down)
                CMD_UP:   state_d = S_UP;
                CMD_DOWN: state_d = S_DOWN;
                default:  state_d = S_IDLE;
            endcase
        end
        incr = (state_q == S_UP);
        decr = (state_q == S_DOWN);
    end

endmodule

// File: rtl/asmd_updown_counter_p.sv
// Parametrised ASMD up/down counter with wrap/saturate, load and boundary flags.
// Optional compare output enabled by defining ASMD_CNT_COMPARE_EN.
module asmd_updown_counter_p
    import asmd_cnt_defs::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int unsigned STEP     = 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIR_W-1:0] up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap,
    output logic [DIR_W-1:0] dir
`ifdef ASMD_CNT_COMPARE_EN
    ,
    input  logic [WIDTH-1:0] cmp_val,
    output logic             match
`endif
);

    localparam int unsigned XW = WIDTH + 1;
    localparam logic [XW-1:0] MAX_X  = XW'(MAX_VAL);
    localparam logic [XW-1:0] STEP_X = XW'(STEP);
    localparam logic [XW-1:0] MOD_X  = MAX_X + XW'(1);

    logic             incr;
    logic             decr;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             clamp_q;
    logic             clamp_d;
    logic [XW-1:0]    cnt_x;
    logic [XW-1:0]    sum_x;
    logic [XW-1:0]    ld_x;

    asmd_cnt_ctrl u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .up_down (up_down),
        .incr    (incr),
        .decr    (decr),
        .dir     (dir)
    );

    assign cnt_x = {1'b0, count_q};
    assign sum_x = cnt_x + STEP_X;
    assign ld_x  = {1'b0, load_val};

    // Next count; clamp_q remembers a clamp last cycle so only the first hit pulses wrap.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        clamp_d = 1'b0;
        if (load) begin
            count_d = (ld_x > MAX_X) ? WIDTH'(MAX_X) : load_val;
        end else if (incr) begin
            if (sum_x <= MAX_X) begin
                count_d = WIDTH'(sum_x);
            end else if (!SATURATE) begin
                count_d = WIDTH'(sum_x - MOD_X);
                wrap_d  = 1'b1;
            end else begin
                count_d = WIDTH'(MAX_X);
                clamp_d = 1'b1;
                wrap_d  = !clamp_q;
            end
        end else if (decr) begin
            if (cnt_x >= STEP_X) begin
                count_d = WIDTH'(cnt_x - STEP_X);
            end else if (!SATURATE) begin
                count_d = WIDTH'(cnt_x + MOD_X - STEP_X);
                wrap_d  = 1'b1;
            end else begin
                count_d = '0;
                clamp_d = 1'b1;
                wrap_d  = !clamp_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            clamp_q <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            clamp_q <= clamp_d;
        end
    end

`ifdef ASMD_CNT_COMPARE_EN
    logic match_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= (count_q == cmp_val);
        end
    end

    assign match = match_q;
`endif

    assign count  = count_q;
    assign wrap   = wrap_q;
    assign at_max = (cnt_x == MAX_X);
    assign at_min = (count_q == '0);

endmodule

// File: tb/tb_asmd_updown_counter_p.sv
// Bench for asmd_updown_counter_p: four parameter sets driven in lockstep
// against a modular-arithmetic reference model, plus directed plan checks.
module tb_asmd_updown_counter_p;

    localparam int N = 4;
    localparam int MXA [N] = '{15, 15, 10, 10};
    localparam int STA [N] = '{1, 2, 3, 1};
    localparam int SAA [N] = '{0, 0, 1, 1};

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] up_down;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] cmp_val;

    logic [3:0] c_o   [N];
    logic       mx_o  [N];
    logic       mn_o  [N];
    logic       w_o   [N];
    logic [1:0] d_o   [N];
    logic       mt_o  [N];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int   m_cnt [N];
    int   m_st  [N];
    int   m_prev_clamp [N];
    int   m_wrap [N];
    int   m_match [N];
    int   wrap_seen;

`ifdef ASMD_CNT_COMPARE_EN
    `define TB_CMP(i) , .cmp_val(cmp_val), .match(mt_o[i])
`else
    `define TB_CMP(i)
`endif

    asmd_updown_counter_p #(.WIDTH(4)) d0 (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .count(c_o[0]), .at_max(mx_o[0]), .at_min(mn_o[0]),
        .wrap(w_o[0]), .dir(d_o[0]) `TB_CMP(0));
    asmd_updown_counter_p #(.WIDTH(4), .STEP(2)) d1 (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .count(c_o[1]), .at_max(mx_o[1]), .at_min(mn_o[1]),
        .wrap(w_o[1]), .dir(d_o[1]) `TB_CMP(1));
    asmd_updown_counter_p #(.WIDTH(4), .MAX_VAL(10), .STEP(3), .SATURATE(1'b1)) d2 (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .count(c_o[2]), .at_max(mx_o[2]), .at_min(mn_o[2]),
        .wrap(w_o[2]), .dir(d_o[2]) `TB_CMP(2));
    asmd_updown_counter_p #(.WIDTH(4), .MAX_VAL(10), .STEP(1), .SATURATE(1'b1)) d3 (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .count(c_o[3]), .at_max(mx_o[3]), .at_min(mn_o[3]),
        .wrap(w_o[3]), .dir(d_o[3]) `TB_CMP(3));

`ifndef ASMD_CNT_COMPARE_EN
    initial for (int i = 0; i < N; i++) mt_o[i] = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = 0; m_st[k] = 0; m_prev_clamp[k] = 0;
            m_wrap[k] = 0; m_match[k] = 0;
        end
    endfunction

    // One clock edge of the specified behaviour, in modular arithmetic.
    function automatic void model_edge();
        for (int k = 0; k < N; k++) begin
            int m, c, clamp;
            m = MXA[k] + 1;
            c = m_cnt[k];
            clamp = 0;
            m_match[k] = (c == int'(cmp_val)) ? 1 : 0;
            m_wrap[k] = 0;
            if (load) begin
                c = (int'(load_val) > MXA[k]) ? MXA[k] : int'(load_val);
            end else if (m_st[k] == 1) begin
                if (c + STA[k] <= MXA[k]) c = c + STA[k];
                else if (SAA[k] == 0) begin c = (c + STA[k]) % m; m_wrap[k] = 1; end
                else begin c = MXA[k]; clamp = 1; m_wrap[k] = m_prev_clamp[k] ? 0 : 1; end
            end else if (m_st[k] == 2) begin
                if (c - STA[k] >= 0) c = c - STA[k];
                else if (SAA[k] == 0) begin c = (c - STA[k] + m) % m; m_wrap[k] = 1; end
                else begin c = 0; clamp = 1; m_wrap[k] = m_prev_clamp[k] ? 0 : 1; end
            end
            m_cnt[k] = c;
            m_prev_clamp[k] = clamp;
            if (en) m_st[k] = (up_down == 2'b01) ? 1 : (up_down == 2'b10) ? 2 : 0;
        end
    endfunction

    task automatic check_all();
        for (int k = 0; k < N; k++) begin
            chk("count", k, 32'(c_o[k]), 32'(m_cnt[k]));
            chk("wrap", k, 32'(w_o[k]), 32'(m_wrap[k]));
            chk("dir", k, 32'(d_o[k]), 32'(m_st[k]));
            chk("at_max", k, 32'(mx_o[k]), 32'(m_cnt[k] == MXA[k]));
            chk("at_min", k, 32'(mn_o[k]), 32'(m_cnt[k] == 0));
`ifdef ASMD_CNT_COMPARE_EN
            chk("match", k, 32'(mt_o[k]), 32'(m_match[k]));
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_count", 0, 32'(c_o[0]), 32'd0);
        chk("rst_dir", 0, 32'(d_o[0]), 32'd0);
        #2 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up_down = 2'b00; load = 1'b0;
        load_val = 4'd0; cmp_val = 4'd5; wrap_seen = 0;
        model_reset();
        #2;
        check_all();
        chk("rst_at_min", 0, 32'(mn_o[0]), 32'd1);
        chk("rst_at_max", 0, 32'(mx_o[0]), 32'd0);
        #10 reset = 1'b0;

        // Count up for 17 edges: d0 goes 0,1..15,0
        en = 1'b1; up_down = 2'b01;
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("p_up_cnt", 0, 32'(c_o[0]), 32'((i <= 1) ? 0 : (i - 1) % 16));
            chk("p_up_max", 0, 32'(mx_o[0]), 32'(i == 16));
            chk("p_up_wrap", 0, 32'(w_o[0]), 32'(i == 17));
        end

        // Load 3, then count down by 2 on d1: 3,3,1,15
        load = 1'b1; load_val = 4'd3; up_down = 2'b00;
        tick();
        chk("p_dn_cnt", 1, 32'(c_o[1]), 32'd3);
        #1 load = 1'b0; up_down = 2'b10;
        tick(); chk("p_dn_cnt", 1, 32'(c_o[1]), 32'd3);
        chk("p_dn_min", 1, 32'(mn_o[1]), 32'd0);
        tick(); chk("p_dn_cnt", 1, 32'(c_o[1]), 32'd1);
        chk("p_dn_min", 1, 32'(mn_o[1]), 32'd0);
        tick(); chk("p_dn_cnt", 1, 32'(c_o[1]), 32'd15);
        chk("p_dn_wrap", 1, 32'(w_o[1]), 32'd1);
        chk("p_dn_min", 1, 32'(mn_o[1]), 32'd0);

        // Load 9 together with up: saturating d3 goes 9,10,10,10, one wrap pulse
        #1 load = 1'b1; load_val = 4'd9; up_down = 2'b01;
        tick();
        chk("p_sat_cnt", 3, 32'(c_o[3]), 32'd9);
        #1 load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("p_sat_cnt", 3, 32'(c_o[3]), 32'd10);
            wrap_seen += int'(w_o[3]);
        end
        chk("p_sat_wraps", 3, 32'(wrap_seen), 32'd1);

        // Down from 1 with STEP=3 clamps to 0 with a wrap pulse
        #1 load = 1'b1; load_val = 4'd1; up_down = 2'b10;
        tick();
        #1 load = 1'b0;
        tick();
        chk("p_clamp0_cnt", 2, 32'(c_o[2]), 32'd0);
        chk("p_clamp0_wrap", 2, 32'(w_o[2]), 32'd1);

        // Out-of-range load clamps to MAX_VAL; en=0 still loads
        #1 load = 1'b1; load_val = 4'd15; en = 1'b0;
        tick();
        chk("p_ld_clamp", 2, 32'(c_o[2]), 32'd10);
        chk("p_ld_clamp", 3, 32'(c_o[3]), 32'd10);
        #1 load = 1'b0; en = 1'b1; up_down = 2'b01;
        load_val = 4'd0; load = 1'b1;
        tick();
        #1 load = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Asynchronous reset mid-count, then restart
        mid_reset();
        tick();
        chk("p_rel_dir", 0, 32'(d_o[0]), 32'd1);
        chk("p_rel_cnt", 0, 32'(c_o[0]), 32'd0);
        tick();
        chk("p_rel_cnt", 0, 32'(c_o[0]), 32'd1);

        // Randomised run with sticky commands so wraps and clamps occur
        for (int i = 0; i < 600; i++) begin
            #1;
            en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) up_down = 2'($urandom_range(0, 3));
            load = ($urandom_range(0, 11) == 0);
            load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) cmp_val = 4'($urandom_range(0, 15));
            if (i == 300) mid_reset();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
